// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: next-PC select encodings,
// FSM state type and the default reset vector.
package fetch_unit_pkg;

    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_JALR = 2'b10;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_ERR   = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: sequential, PC-relative branch/JAL, or
// JALR target with bit 0 cleared. All arithmetic wraps modulo 2^32.
module fetch_next_pc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_in,
    input  logic [31:0] imm_ext,
    input  logic [31:0] alu_result,
    output logic [31:0] next_pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] w_seq;

    assign w_seq    = pc + 32'd4;
    assign pc_plus4 = w_seq;

    always_comb begin
        unique case (pc_in)
            PC_BR:   next_pc = pc + imm_ext;
            PC_JALR: next_pc = {alu_result[31:1], 1'b0};
            default: next_pc = w_seq;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: requests a word at pc, holds it
// for the datapath until retire, then advances pc. A stuck memory parks it in ERR.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter int          IMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pc_in,
    input  logic [31:0] imm_ext,
    input  logic [31:0] alu_result,
    input  logic        retire,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [6:0]  op,
    output logic [2:0]  f3,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    localparam int CW = $clog2(IMEM_TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(IMEM_TIMEOUT - 1);

    fetch_state_t r_state, w_next_state;
    logic [31:0]  r_pc, r_instr, w_next_pc;
    logic [CW-1:0] r_wait, w_wait_next;
    logic         w_latch, w_advance;

    fetch_next_pc u_next_pc (
        .pc         (r_pc),
        .pc_in      (pc_in),
        .imm_ext    (imm_ext),
        .alu_result (alu_result),
        .next_pc    (w_next_pc),
        .pc_plus4   (pc_plus4)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_next_state = r_state;
        w_wait_next  = r_wait;
        w_latch      = 1'b0;
        w_advance    = 1'b0;
        unique case (r_state)
            ST_FETCH: begin
                if (imem_ack) begin
                    w_latch      = 1'b1;
                    w_wait_next  = '0;
                    w_next_state = ST_EXEC;
                end else if (r_wait == WAIT_LAST) begin
                    w_next_state = ST_ERR;
                end else begin
                    w_wait_next = r_wait + CW'(1);
                end
            end
            ST_EXEC: begin
                if (retire) begin
                    w_advance    = 1'b1;
                    w_next_state = ST_FETCH;
                end
            end
            default: w_next_state = r_state;
        endcase
    end

    // NOTE: state uses non-blocking assignments and an async reset, so a reset
    // mid-instruction clears everything without waiting for an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_next_state;
            r_wait  <= w_wait_next;
            if (w_latch)   r_instr <= imem_rdata;
            if (w_advance) r_pc    <= w_next_pc;
        end
    end

    // Gated by rst so no request is issued while the unit is held in reset.
    assign imem_req    = (r_state == ST_FETCH) && !rst;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign instr_valid = (r_state == ST_EXEC);
    assign fetch_err   = (r_state == ST_ERR);
    assign op          = r_instr[6:0];
    assign f3          = r_instr[14:12];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pc_in = 2'b00;
    logic [31:0] imm_ext = '0, alu_result = '0, imem_rdata = '0;
    logic        retire = 1'b0, imem_ack = 1'b0;
    logic        imem_req, instr_valid, fetch_err;
    logic [31:0] imem_addr, instr, pc, pc_plus4;
    logic [6:0]  op;
    logic [2:0]  f3;

    int n_pass = 0;
    int n_total = 0;

    fetch_unit dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .imm_ext(imm_ext),
        .alu_result(alu_result), .retire(retire), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .op(op), .f3(f3), .pc(pc),
        .pc_plus4(pc_plus4), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        retire = 1'b0; imem_ack = 1'b0; pc_in = 2'b00;
        imm_ext = '0; alu_result = '0; imem_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic fetch_word(input logic [31:0] data);
        imem_ack = 1'b1; imem_rdata = data;
        tick();
        imem_ack = 1'b0;
    endtask

    task automatic retire_with(input logic [1:0] sel, input logic [31:0] imm, input logic [31:0] alu);
        retire = 1'b1; pc_in = sel; imm_ext = imm; alu_result = alu;
        tick();
        retire = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++; if (pc !== 32'h0) $display("FAIL reset_pc got %h want %h", pc, 32'h0); else n_pass++;
        n_total++; if (instr !== 32'h0) $display("FAIL reset_instr got %h want 0", instr); else n_pass++;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", instr_valid); else n_pass++;
        n_total++; if (fetch_err !== 1'b0) $display("FAIL reset_err got %b want 0", fetch_err); else n_pass++;
        n_total++; if (imem_req !== 1'b0) $display("FAIL reset_req got %b want 0", imem_req); else n_pass++;
    endtask

    task automatic test_first_fetch();
        do_reset();
        imem_ack = 1'b1; imem_rdata = 32'h0000_1234;
        #1;
        n_total++; if (imem_req !== 1'b1) $display("FAIL first_req got %b want 1", imem_req); else n_pass++;
        n_total++; if (imem_addr !== 32'h0) $display("FAIL first_addr got %h want 0", imem_addr); else n_pass++;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL first_valid_early got %b want 0", instr_valid); else n_pass++;
        tick();
        imem_ack = 1'b0;
        n_total++; if (instr_valid !== 1'b1) $display("FAIL first_valid got %b want 1", instr_valid); else n_pass++;
        n_total++; if (instr !== 32'h0000_1234) $display("FAIL first_instr got %h want 00001234", instr); else n_pass++;
        n_total++; if (op !== 7'h34) $display("FAIL first_op got %h want 34", op); else n_pass++;
        n_total++; if (f3 !== 3'b001) $display("FAIL first_f3 got %b want 001", f3); else n_pass++;
        n_total++; if (imem_req !== 1'b0) $display("FAIL exec_req got %b want 0", imem_req); else n_pass++;
        n_total++; if (pc_plus4 !== 32'h4) $display("FAIL first_pc_plus4 got %h want 4", pc_plus4); else n_pass++;
    endtask

    task automatic test_branch_jalr();
        do_reset();
        fetch_word(32'h13);
        retire_with(2'b10, 32'h0, 32'h0000_0100);
        n_total++; if (imem_addr !== 32'h100) $display("FAIL jalr_setup got %h want 100", imem_addr); else n_pass++;
        fetch_word(32'h63);
        retire_with(2'b01, 32'hFFFF_FFF8, 32'h0);
        n_total++; if (imem_addr !== 32'hF8) $display("FAIL branch_back got %h want f8", imem_addr); else n_pass++;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL retire_valid got %b want 0", instr_valid); else n_pass++;
        fetch_word(32'h67);
        retire_with(2'b10, 32'h0, 32'h0000_0203);
        n_total++; if (imem_addr !== 32'h202) $display("FAIL jalr_lsb got %h want 202", imem_addr); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [1:0] sels [2] = '{2'b00, 2'b11};
        foreach (sels[k]) begin
            fetch_word(32'h13);
            retire_with(2'b10, 32'h0, 32'hFFFF_FFFC);
            fetch_word(32'h13);
            n_total++; if (pc_plus4 !== 32'h0) $display("FAIL wrap_plus4 sel=%b got %h want 0", sels[k], pc_plus4); else n_pass++;
            retire_with(sels[k], 32'h1111_0000, 32'h2222_0000);
            n_total++; if (imem_addr !== 32'h0) $display("FAIL wrap_addr sel=%b got %h want 0", sels[k], imem_addr); else n_pass++;
        end
    endtask

    task automatic test_timeout();
        do_reset();
        repeat (15) tick();
        n_total++; if (fetch_err !== 1'b0) $display("FAIL timeout_early got %b want 0", fetch_err); else n_pass++;
        n_total++; if (imem_req !== 1'b1) $display("FAIL timeout_req_early got %b want 1", imem_req); else n_pass++;
        tick();
        n_total++; if (fetch_err !== 1'b1) $display("FAIL timeout_err got %b want 1", fetch_err); else n_pass++;
        n_total++; if (imem_req !== 1'b0) $display("FAIL timeout_req got %b want 0", imem_req); else n_pass++;
        imem_ack = 1'b1; retire = 1'b1; imem_rdata = 32'hABCD_EF01; pc_in = 2'b10; alu_result = 32'h500;
        repeat (4) tick();
        idle_inputs();
        n_total++; if (fetch_err !== 1'b1) $display("FAIL err_sticky got %b want 1", fetch_err); else n_pass++;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL err_valid got %b want 0", instr_valid); else n_pass++;
        n_total++; if (pc !== 32'h0) $display("FAIL err_pc got %h want 0", pc); else n_pass++;
        n_total++; if (imem_req !== 1'b0) $display("FAIL err_req got %b want 0", imem_req); else n_pass++;
    endtask

    task automatic test_delayed_ack();
        do_reset();
        retire = 1'b1; pc_in = 2'b01; imm_ext = 32'h40;
        repeat (3) tick();
        n_total++; if (pc !== 32'h0) $display("FAIL stray_retire_pc got %h want 0", pc); else n_pass++;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL delayed_valid_early got %b want 0", instr_valid); else n_pass++;
        retire = 1'b0;
        fetch_word(32'h0000_5033);
        n_total++; if (instr_valid !== 1'b1) $display("FAIL delayed_valid got %b want 1", instr_valid); else n_pass++;
        n_total++; if (f3 !== 3'b101) $display("FAIL delayed_f3 got %b want 101", f3); else n_pass++;
        n_total++; if (pc !== 32'h0) $display("FAIL delayed_pc got %h want 0", pc); else n_pass++;
    endtask

    task automatic test_reset_exec();
        do_reset();
        fetch_word(32'h13);
        retire_with(2'b10, 32'h0, 32'h40);
        fetch_word(32'h33);
        n_total++; if (pc !== 32'h40 || instr_valid !== 1'b1) $display("FAIL exec_setup got pc=%h v=%b want 40/1", pc, instr_valid); else n_pass++;
        #2 rst = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        n_total++; if (pc !== 32'h0) $display("FAIL async_pc got %h want 0", pc); else n_pass++;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL async_valid got %b want 0", instr_valid); else n_pass++;
        repeat (2) @(negedge clk);
        imem_ack = 1'b0;
        rst = 1'b0;
        #1;
        n_total++; if (instr !== 32'h0) $display("FAIL late_ack_latched got %h want 0", instr); else n_pass++;
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL refetch got req=%b addr=%h want 1/0", imem_req, imem_addr); else n_pass++;
        tick();
        n_total++; if (instr_valid !== 1'b0) $display("FAIL post_reset_valid got %b want 0", instr_valid); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] m_pc = 32'h0, m_instr = 32'h0;
        logic        m_busy = 1'b0, m_err = 1'b0;
        int          m_waits = 0;
        logic [31:0] target;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            imem_ack   = ($urandom_range(0, 99) < 45);
            retire     = ($urandom_range(0, 99) < 55);
            pc_in      = 2'($urandom_range(0, 3));
            imm_ext    = {{20{$urandom_range(0, 1) == 1}}, 12'($urandom)};
            alu_result = $urandom;
            imem_rdata = $urandom;
            @(posedge clk);
            if (m_err) begin
            end else if (!m_busy) begin
                if (imem_ack) begin
                    m_instr = imem_rdata; m_busy = 1'b1; m_waits = 0;
                end else begin
                    m_waits++;
                    if (m_waits == 16) m_err = 1'b1;
                end
            end else if (retire) begin
                if (pc_in == 2'b01)      target = m_pc + imm_ext;
                else if (pc_in == 2'b10) target = alu_result & 32'hFFFF_FFFE;
                else                     target = m_pc + 32'd4;
                m_pc = target; m_busy = 1'b0;
            end
            @(negedge clk);
            n_total++;
            if (pc !== m_pc || imem_addr !== m_pc || pc_plus4 !== m_pc + 32'd4)
                $display("FAIL rand_pc cyc=%0d got pc=%h addr=%h p4=%h want %h", cyc, pc, imem_addr, pc_plus4, m_pc);
            else n_pass++;
            n_total++;
            if (instr_valid !== m_busy || imem_req !== (!m_busy && !m_err) || fetch_err !== m_err)
                $display("FAIL rand_ctrl cyc=%0d got v=%b req=%b err=%b want v=%b err=%b", cyc, instr_valid, imem_req, fetch_err, m_busy, m_err);
            else n_pass++;
            if (m_busy) begin
                n_total++;
                if (instr !== m_instr || op !== m_instr[6:0] || f3 !== m_instr[14:12])
                    $display("FAIL rand_instr cyc=%0d got %h op=%h f3=%b want %h", cyc, instr, op, f3, m_instr);
                else n_pass++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_branch_jalr();
        test_wrap();
        test_timeout();
        test_delayed_ack();
        test_reset_exec();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning: PC value loaded on reset.
REQ-002 Parameter IMEM_TIMEOUT, default 16, meaning: wait cycles on imem_ack before fetch_err is raised.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 pc_in  in  2  next-PC select from controller: 00 PC+4, 01 PC+imm_ext, 10 alu_result, 11 PC+4.
REQ-006 imm_ext  in  32  sign-extended byte offset for branch/JAL targets.
REQ-007 alu_result  in  32  JALR target from datapath ALU.
REQ-008 retire  in  1  datapath has committed the presented instruction this cycle.
REQ-009 imem_req  out  1  fetch request to instruction memory.
REQ-010 imem_addr  out  32  fetch byte address; equals pc.
REQ-011 imem_ack  in  1  imem_rdata valid this cycle.
REQ-012 imem_rdata  in  32  fetched instruction word.
REQ-013 instr  out  32  registered instruction presented to datapath.
REQ-014 instr_valid  out  1  instr, op, f3 and pc are valid for execution.
REQ-015 op  out  7  instr[6:0], to controller Op.
REQ-016 f3  out  3  instr[14:12], to controller F3.
REQ-017 pc  out  32  address of the current instruction.
REQ-018 pc_plus4  out  32  pc+4, link value for JAL/JALR writeback.
REQ-019 fetch_err  out  1  sticky: imem_ack not seen within IMEM_TIMEOUT cycles.

Function
REQ-020 The FSM SHALL have states FETCH, EXEC, ERR; reset state FETCH.
REQ-021 In FETCH the block SHALL assert imem_req with imem_addr=pc and increment a wait counter each cycle imem_ack is low.
REQ-022 On imem_ack in FETCH the block SHALL latch imem_rdata into instr, clear the wait counter and enter EXEC on the next edge (instr_valid high one cycle after ack).
REQ-023 In EXEC imem_req SHALL be low and instr_valid high; instr and pc SHALL hold until retire.
REQ-024 On retire in EXEC the block SHALL load pc with next_pc, deassert instr_valid and return to FETCH on the same edge.
REQ-025 next_pc SHALL be pc+4 for pc_in 00/11, pc+imm_ext for 01, {alu_result[31:1],1'b0} for 10; sampled only in the retire cycle.
REQ-026 All PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-027 retire while not in EXEC and imem_ack while not in FETCH SHALL be ignored.
REQ-028 If the wait counter reaches IMEM_TIMEOUT in FETCH the block SHALL enter ERR, set fetch_err, drop imem_req; ERR exits only by reset.
REQ-029 op, f3, pc_plus4 SHALL be combinational from the instr and pc registers.
REQ-030 Minimum throughput: one instruction per 2 cycles (ack in the first FETCH cycle, retire in the first EXEC cycle).

Reset
REQ-031 On rst: pc=RESET_PC, instr=0, instr_valid=0, fetch_err=0, wait counter=0, state=FETCH; imem_req goes high in the first cycle after rst deasserts.
REQ-032 Reset mid-fetch or mid-EXEC SHALL discard the in-flight instruction; a late imem_ack arriving during reset SHALL not be latched.

Structure
REQ-033 A shared package SHALL hold the pc_in encodings (PC_SEQ=00, PC_BR=01, PC_JALR=10), the FSM state type and the default RESET_PC.
REQ-034 Next-PC selection SHALL be a combinational sub-module fetch_next_pc (pc, pc_in, imm_ext, alu_result -> next_pc, pc_plus4).

Verification
REQ-035 Reset release, imem_ack same cycle, rdata 32'h0000_1234 -> imem_addr 0; instr_valid next cycle, op 7'h34, f3 3'b001.
REQ-036 pc=0x100, retire with pc_in 01, imm_ext 0xFFFF_FFF8 -> next imem_addr 0xF8; pc_in 10, alu_result 0x203 -> 0x202.
REQ-037 pc=0xFFFF_FFFC, retire with pc_in 00 -> imem_addr 0x0; pc_in 11 behaves identically.
REQ-038 imem_ack held low 16 cycles -> fetch_err=1, imem_req=0, retire and imem_ack ignored until rst.
REQ-039 imem_ack delayed 3 cycles, retire pulsed during FETCH -> no PC change, instr_valid rises one cycle after ack.
REQ-040 rst asserted in EXEC with pc=0x40 -> pc=RESET_PC, instr_valid=0 immediately (asynchronous), refetch from RESET_PC after release.
